// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-side and a data-side requester onto one shared memory
// port. D-side bursts are bounded while I-side waits, and every access has a MACK timeout.
module mem_port_arbiter #(
    parameter int unsigned MAX_DBURST = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        IREQ,
    input  logic [29:0] IADDR,
    output logic        IDONE,
    output logic [31:0] IRDATA,
    input  logic        DREQ,
    input  logic        DRW,
    input  logic [29:0] DADDR,
    input  logic [31:0] DWDATA,
    output logic        DDONE,
    output logic [31:0] DRDATA,
    output logic        MREQ,
    output logic        MRW,
    output logic [29:0] MADDR,
    output logic [31:0] MWDATA,
    input  logic [31:0] MRDATA,
    input  logic        MACK,
    output logic        ERR
);
    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = $clog2(MAX_DBURST + 1);
    localparam int unsigned SW = (BW > 3) ? BW : 3;
    localparam int unsigned TW = 8;
    localparam logic [SW-1:0] STREAK_MAX = '1;
    localparam logic [SW-1:0] BURST_LIM  = SW'(MAX_DBURST);
    localparam logic [TW-1:0] TMO_LIM    = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          mreq_q, mreq_d;
    logic          mrw_q, mrw_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [DW-1:0] mwdata_q, mwdata_d;
    logic          idone_q, idone_d;
    logic          ddone_q, ddone_d;
    logic          err_q, err_d;
    logic [DW-1:0] irdata_q, irdata_d;
    logic [DW-1:0] drdata_q, drdata_d;
    logic          expire;

    // Next state, arbitration and registered-output next values
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        tmo_d    = tmo_q;
        mreq_d   = mreq_q;
        mrw_d    = mrw_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        idone_d  = 1'b0;
        ddone_d  = 1'b0;
        err_d    = 1'b0;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        expire   = (TW'(tmo_q + 1'b1) == TMO_LIM);

        case (state_q)
            IDLE: begin
                if (DREQ && (!IREQ || (streak_q < BURST_LIM))) begin
                    state_d  = DACC;
                    mreq_d   = 1'b1;
                    mrw_d    = DRW;
                    maddr_d  = DADDR;
                    mwdata_d = DWDATA;
                    tmo_d    = '0;
                    if (!IREQ)
                        streak_d = '0;
                    else if (streak_q != STREAK_MAX)
                        streak_d = SW'(streak_q + 1'b1);
                end else if (IREQ) begin
                    state_d  = IACC;
                    mreq_d   = 1'b1;
                    mrw_d    = 1'b0;
                    maddr_d  = IADDR;
                    tmo_d    = '0;
                    streak_d = '0;
                end
            end
            IACC, DACC: begin
                // MACK takes priority over a coincident timeout expiry
                if (MACK || expire) begin
                    state_d = IDLE;
                    mreq_d  = 1'b0;
                    err_d   = !MACK;
                    idone_d = (state_q == IACC);
                    ddone_d = (state_q == DACC);
                    if (MACK && (state_q == IACC))
                        irdata_d = MRDATA;
                    if (MACK && (state_q == DACC) && !mrw_q)
                        drdata_d = MRDATA;
                end else begin
                    tmo_d = TW'(tmo_q + 1'b1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            streak_q <= '0;
            tmo_q    <= '0;
            mreq_q   <= 1'b0;
            mrw_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            idone_q  <= 1'b0;
            ddone_q  <= 1'b0;
            err_q    <= 1'b0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            tmo_q    <= tmo_d;
            mreq_q   <= mreq_d;
            mrw_q    <= mrw_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            idone_q  <= idone_d;
            ddone_q  <= ddone_d;
            err_q    <= err_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
        end
    end

    assign MREQ   = mreq_q;
    assign MRW    = mrw_q;
    assign MADDR  = maddr_q;
    assign MWDATA = mwdata_q;
    assign IDONE  = idone_q;
    assign DDONE  = ddone_q;
    assign ERR    = err_q;
    assign IRDATA = irdata_q;
    assign DRDATA = drdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences
// and a randomized run against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int TMO   = 16;
    localparam int BURST = 4;

    logic        CLK;
    logic        RSTN;
    logic        IREQ, DREQ, DRW, MACK;
    logic [29:0] IADDR, DADDR;
    logic [31:0] DWDATA, MRDATA;
    logic        IDONE, DDONE, MREQ, MRW, ERR;
    logic [31:0] IRDATA, DRDATA, MWDATA;
    logic [29:0] MADDR;

    int n_chk  = 0;
    int n_pass = 0;

    mem_port_arbiter #(.MAX_DBURST(BURST), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .IREQ(IREQ), .IADDR(IADDR), .IDONE(IDONE), .IRDATA(IRDATA),
        .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA),
        .DDONE(DDONE), .DRDATA(DRDATA),
        .MREQ(MREQ), .MRW(MRW), .MADDR(MADDR), .MWDATA(MWDATA),
        .MRDATA(MRDATA), .MACK(MACK), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"},    64'({MREQ, MRW, IDONE, DDONE, ERR}), 64'(0));
        chk({tag, "_maddr"},  64'(MADDR),  64'(0));
        chk({tag, "_mwdata"}, 64'(MWDATA), 64'(0));
        chk({tag, "_irdata"}, 64'(IRDATA), 64'(0));
        chk({tag, "_drdata"}, 64'(DRDATA), 64'(0));
    endtask

    typedef struct {
        logic        is_d;
        logic        rw;
        logic [29:0] addr;
        logic [31:0] wdata;
        int          lat;      // access cycle that carries MACK, 0 = never
        logic [31:0] rdata;
        logic        exp_err;
        int          exp_cyc;  // grant edge to DONE, in cycles
        logic [31:0] exp_rd;   // IRDATA or DRDATA after the access
    } vec_t;

    typedef struct {
        logic        rw;
        logic [29:0] addr;
        logic [31:0] wdata;
    } dtx_t;

    vec_t        vecs[7];
    logic [29:0] iq[$];
    dtx_t        dq[$];

    initial begin
        int          cyc, acc, ng;
        bit          got_done;
        bit          got_d[10];
        bit          busy, side, done_now, done_side, done_err, was_busy;
        int          ack_at, streak, r;
        logic        cur_rw;
        logic [29:0] cur_addr;
        logic [31:0] cur_wd, e_ird, e_drd;

        vecs[0] = '{1'b0, 1'b0, 30'h10,       32'h0,        3,  32'hDEADBEEF, 1'b0, 4,  32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b0, 30'h21,       32'h0,        1,  32'hCAFEF00D, 1'b0, 2,  32'hCAFEF00D};
        vecs[2] = '{1'b1, 1'b1, 30'h20,       32'h12345678, 2,  32'hBAD0BAD0, 1'b0, 3,  32'hCAFEF00D};
        vecs[3] = '{1'b1, 1'b0, 30'h22,       32'h0,        0,  32'h11111111, 1'b1, 17, 32'hCAFEF00D};
        vecs[4] = '{1'b0, 1'b0, 30'h3FFFFFFF, 32'h0,        16, 32'h0F0F0F0F, 1'b0, 17, 32'h0F0F0F0F};
        vecs[5] = '{1'b0, 1'b0, 30'h11,       32'h0,        0,  32'h22222222, 1'b1, 17, 32'h0F0F0F0F};
        vecs[6] = '{1'b1, 1'b0, 30'h15555555, 32'h0,        15, 32'h55AA55AA, 1'b0, 16, 32'h55AA55AA};

        RSTN = 1'b0; IREQ = 1'b0; DREQ = 1'b0; DRW = 1'b0; MACK = 1'b0;
        IADDR = '0; DADDR = '0; DWDATA = '0; MRDATA = '0;
        repeat (2) @(negedge CLK);
        chk_zero("reset");
        RSTN = 1'b1;

        // Directed single accesses; requester drops REQ right after the grant
        for (int v = 0; v < 7; v++) begin
            @(negedge CLK);
            IREQ = !vecs[v].is_d; DREQ = vecs[v].is_d;
            IADDR = vecs[v].addr; DADDR = vecs[v].addr;
            DRW = vecs[v].rw; DWDATA = vecs[v].wdata; MACK = 1'b0;
            cyc = 0; acc = 0; got_done = 1'b0;
            while (!got_done && cyc < 40) begin
                @(negedge CLK);
                cyc++;
                if (IDONE || DDONE) begin
                    got_done = 1'b1;
                    chk($sformatf("vec%0d_side", v), 64'({IDONE, DDONE}),
                        64'(vecs[v].is_d ? 2'b01 : 2'b10));
                    chk($sformatf("vec%0d_err", v), 64'(ERR), 64'(vecs[v].exp_err));
                    chk($sformatf("vec%0d_latency", v), 64'(cyc), 64'(vecs[v].exp_cyc));
                    chk($sformatf("vec%0d_mreq_low", v), 64'(MREQ), 64'(0));
                    chk($sformatf("vec%0d_rdata", v),
                        64'(vecs[v].is_d ? DRDATA : IRDATA), 64'(vecs[v].exp_rd));
                end else begin
                    acc++;
                    chk($sformatf("vec%0d_mreq", v), 64'(MREQ), 64'(1));
                    chk($sformatf("vec%0d_maddr", v), 64'(MADDR), 64'(vecs[v].addr));
                    chk($sformatf("vec%0d_mrw", v), 64'(MRW), 64'(vecs[v].is_d & vecs[v].rw));
                    if (vecs[v].is_d)
                        chk($sformatf("vec%0d_mwdata", v), 64'(MWDATA), 64'(vecs[v].wdata));
                    IREQ = 1'b0; DREQ = 1'b0;
                    MACK = (acc == vecs[v].lat);
                    MRDATA = MACK ? vecs[v].rdata : ~vecs[v].rdata;
                end
            end
            MACK = 1'b0;
            chk($sformatf("vec%0d_done_seen", v), 64'(got_done), 64'(1));
        end

        // Both sides held: D limited to a burst of BURST while I waits
        @(negedge CLK);
        IREQ = 1'b1; DREQ = 1'b1; DRW = 1'b0;
        IADDR = 30'h100; DADDR = 30'h200; MACK = 1'b0;
        ng = 0; acc = 0; cyc = 0;
        while (ng < 10 && cyc < 300) begin
            @(negedge CLK);
            cyc++;
            if (MREQ) begin
                if (acc == 0) begin
                    got_d[ng] = (MADDR == 30'h200);
                    ng++;
                end
                acc++;
            end else begin
                acc = 0;
            end
            MACK = MREQ && (acc == 2);
        end
        IREQ = 1'b0; DREQ = 1'b0;
        for (int k = 0; k < 20 && MREQ; k++) begin
            @(negedge CLK);
            if (MREQ) acc++;
            MACK = MREQ && (acc == 2);
        end
        MACK = 1'b0;
        @(negedge CLK);
        chk("order_count", 64'(ng), 64'(10));
        for (int i = 0; i < ng; i++)
            chk($sformatf("order_grant%0d_is_d", i), 64'(got_d[i]), 64'((i % (BURST + 1)) != BURST));

        // Reset in the middle of an I access
        @(negedge CLK);
        IREQ = 1'b1; IADDR = 30'h44; MACK = 1'b0;
        @(negedge CLK);
        chk("rstmid_mreq_before", 64'(MREQ), 64'(1));
        @(negedge CLK);
        RSTN = 1'b0;
        #1;
        chk_zero("rstmid_async");
        IADDR = 30'h48;
        repeat (2) begin
            @(negedge CLK);
            chk("rstmid_quiet", 64'({MREQ, IDONE, DDONE, ERR}), 64'(0));
        end
        RSTN = 1'b1;
        @(negedge CLK);
        chk("rstmid_regrant_mreq", 64'(MREQ), 64'(1));
        chk("rstmid_regrant_maddr", 64'(MADDR), 64'(30'h48));
        chk("rstmid_regrant_mrw", 64'(MRW), 64'(0));
        IREQ = 1'b0; MACK = 1'b1; MRDATA = 32'hA5A50048;
        @(negedge CLK);
        MACK = 1'b0;
        chk("rstmid_done", 64'({IDONE, DDONE, ERR}), 64'(3'b100));
        chk("rstmid_irdata", 64'(IRDATA), 64'(32'hA5A50048));

        // Randomized traffic against a transaction-level model
        RSTN = 1'b0;
        @(negedge CLK);
        RSTN = 1'b1;
        for (int i = 0; i < 25; i++) begin
            dtx_t t;
            iq.push_back(30'($urandom));
            t.rw = 1'($urandom); t.addr = 30'($urandom); t.wdata = $urandom;
            dq.push_back(t);
        end
        busy = 1'b0; side = 1'b0; done_now = 1'b0; done_side = 1'b0; done_err = 1'b0;
        acc = 0; ack_at = 0; streak = 0; cyc = 0;
        cur_rw = 1'b0; cur_addr = '0; cur_wd = '0; e_ird = '0; e_drd = '0;
        while ((iq.size() > 0 || dq.size() > 0 || busy || done_now) && cyc < 6000) begin
            @(negedge CLK);
            cyc++;
            if (done_now) begin
                chk("rnd_done_side", 64'({IDONE, DDONE}), 64'(done_side ? 2'b01 : 2'b10));
                chk("rnd_err", 64'(ERR), 64'(done_err));
            end else begin
                chk("rnd_no_done", 64'({IDONE, DDONE, ERR}), 64'(0));
            end
            chk("rnd_irdata", 64'(IRDATA), 64'(e_ird));
            chk("rnd_drdata", 64'(DRDATA), 64'(e_drd));
            chk("rnd_mreq", 64'(MREQ), 64'(busy));
            if (busy) begin
                chk("rnd_maddr", 64'(MADDR), 64'(cur_addr));
                chk("rnd_mrw", 64'(MRW), 64'(cur_rw));
                if (side) chk("rnd_mwdata", 64'(MWDATA), 64'(cur_wd));
            end
            if (done_now) begin
                if (done_side) void'(dq.pop_front());
                else           void'(iq.pop_front());
                done_now = 1'b0;
            end
            was_busy = busy;
            MRDATA = $urandom;
            if (was_busy) begin
                acc++;
                MACK = (acc == ack_at);
                if (MACK) begin
                    busy = 1'b0; done_now = 1'b1; done_err = 1'b0; done_side = side;
                    if (!side) e_ird = MRDATA;
                    else if (!cur_rw) e_drd = MRDATA;
                end else if (acc == TMO) begin
                    busy = 1'b0; done_now = 1'b1; done_err = 1'b1; done_side = side;
                end
            end else begin
                MACK = ($urandom_range(3) == 0);
            end
            IREQ = (iq.size() > 0) && ($urandom_range(3) != 0);
            DREQ = (dq.size() > 0) && ($urandom_range(3) != 0);
            if (iq.size() > 0) IADDR = iq[0];
            if (dq.size() > 0) begin
                DRW = dq[0].rw; DADDR = dq[0].addr; DWDATA = dq[0].wdata;
            end
            if (!was_busy) begin
                if (DREQ && (!IREQ || streak < BURST)) begin
                    busy = 1'b1; side = 1'b1;
                    cur_rw = dq[0].rw; cur_addr = dq[0].addr; cur_wd = dq[0].wdata;
                    streak = IREQ ? ((streak < 7) ? streak + 1 : 7) : 0;
                end else if (IREQ) begin
                    busy = 1'b1; side = 1'b0;
                    cur_rw = 1'b0; cur_addr = iq[0];
                    streak = 0;
                end
                if (busy) begin
                    acc = 0;
                    r = int'($urandom_range(9));
                    ack_at = (r == 0) ? 0 : (r == 1) ? TMO : r - 1;
                end
            end
        end
        MACK = 1'b0; IREQ = 1'b0; DREQ = 1'b0;
        chk("rnd_all_completed", 64'(iq.size() + dq.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_DBURST, default 4: maximum consecutive D-side grants while I-side is pending.
REQ-002 Parameter TIMEOUT, default 16: cycles an access may wait for MACK before abort; legal range 2..255.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 CLK  in  1  clock; all state changes on rising edge.
REQ-005 RSTN  in  1  asynchronous active-low reset.
REQ-006 IREQ  in  1  instruction-side request; level signal.
REQ-007 IADDR  in  30  instruction word address.
REQ-008 IDONE  out  1  one-cycle pulse: I-side access finished.
REQ-009 IRDATA  out  32  fetched instruction word; valid when IDONE=1 and ERR=0.
REQ-010 DREQ  in  1  data-side request; level signal.
REQ-011 DRW  in  1  1=write, 0=read.
REQ-012 DADDR  in  30  data word address.
REQ-013 DWDATA  in  32  write data.
REQ-014 DDONE  out  1  one-cycle pulse: D-side access finished.
REQ-015 DRDATA  out  32  load data; valid when DDONE=1, DRW was 0 and ERR=0.
REQ-016 MREQ  out  1  shared memory port request, held for the whole access.
REQ-017 MRW  out  1  memory write enable (1=write).
REQ-018 MADDR  out  30  memory word address.
REQ-019 MWDATA  out  32  memory write data.
REQ-020 MRDATA  in  32  memory read data; valid with MACK.
REQ-021 MACK  in  1  memory completion; one cycle, any latency >=1 cycle after MREQ rises.
REQ-022 ERR  out  1  qualifies IDONE/DDONE: 1 = access aborted by timeout.

Function
REQ-023 FSM states SHALL be IDLE, IACC, DACC; all outputs registered.
REQ-024 In IDLE at a rising edge: grant D if DREQ=1 and (IREQ=0 or DSTREAK<MAX_DBURST); else grant I if IREQ=1; else stay IDLE.
REQ-025 On grant SHALL latch address (and DRW/DWDATA for D) into MADDR/MRW/MWDATA and set MREQ=1 from the next cycle; MRW=0 for I accesses.
REQ-026 MREQ, MADDR, MRW, MWDATA SHALL remain stable while in IACC/DACC.
REQ-027 DSTREAK (3+ bits, saturating) SHALL increment on a D grant with IREQ=1, clear on any I grant, and clear on a D grant with IREQ=0.
REQ-028 When MACK=1 is sampled in IACC/DACC: next cycle MREQ=0, state=IDLE, matching DONE=1 for exactly one cycle, ERR=0; read data captured into IRDATA/DRDATA.
REQ-029 D writes SHALL leave DRDATA unchanged.
REQ-030 Access latency: grant edge k -> MREQ high in cycle k+1; MACK in cycle m -> DONE in cycle m+1; minimum grant-to-DONE 2 cycles.
REQ-031 Timeout counter SHALL clear on grant, increment each access cycle without MACK; reaching TIMEOUT SHALL abort: MREQ=0, state IDLE, DONE=1 with ERR=1, read data unchanged.
REQ-032 MACK and TIMEOUT expiry coincident: MACK wins (ERR=0).
REQ-033 MACK sampled in IDLE SHALL be ignored.
REQ-034 Requester dropping REQ mid-access SHALL NOT abort; access completes and DONE still pulses.
REQ-035 REQ still high in the DONE cycle counts as a new request; arbitration in that cycle (IDLE) per REQ-024, allowing back-to-back accesses with one DONE/IDLE cycle between.
REQ-036 IDONE and DDONE SHALL never be high in the same cycle; ERR=0 whenever both DONEs are 0.

Reset
REQ-037 RSTN=0 SHALL immediately force state IDLE, DSTREAK=0, timeout counter=0 and every output to 0 (MREQ, MRW, MADDR, MWDATA, IDONE, DDONE, IRDATA, DRDATA, ERR).
REQ-038 Reset during IACC/DACC SHALL drop MREQ asynchronously with no DONE pulse; after release, first edge arbitrates from IDLE.

Verification
REQ-039 IREQ=1, IADDR=0x10, MACK 3 cycles after MREQ with MRDATA=0xDEADBEEF -> MADDR=0x10, MRW=0, IDONE one cycle, IRDATA=0xDEADBEEF, ERR=0.
REQ-040 IREQ and DREQ (read) held continuously, MACK 1 cycle after each MREQ -> grant order D,D,D,D,I,D,D,D,D,I (MAX_DBURST=4).
REQ-041 DREQ=1, DRW=1, DADDR=0x20, DWDATA=0x12345678 -> MRW=1, MWDATA=0x12345678 stable until MACK; DDONE=1, DRDATA unchanged.
REQ-042 DREQ read, MACK never asserted -> MREQ high exactly 16 cycles, then DDONE=1, ERR=1, DRDATA unchanged, MREQ=0.
REQ-043 RSTN low 2 cycles mid-IACC -> MREQ=0 immediately, no IDONE; after release with IREQ=1, new access to current IADDR.
REQ-044 MACK in the cycle the timeout counter reaches TIMEOUT -> DONE with ERR=0 and data captured.
